uart_rx_fifo: RTL and testbench

Parametrised UART receiver, next generation of the team's 8x-oversampled receiver.
- Configurable data width, oversampling ratio, run-time parity and stop-bit mode.
- Reports per-character framing and parity errors and a sticky overrun flag.
- Buffers received characters in an internal FIFO; the core reads them over a valid/ready interface on the memory-mapped UART peripheral.

---
 rtl/uart_rx_fifo_pkg.sv | 28 ++
 rtl/uart_rx_fifo_if.sv | 22 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 76 +++++++
 rtl/uart_rx_fifo.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the uart_rx_fifo receiver.
// Optional break detection is selected with the macro UART_RX_BREAK_DET_EN;
// it adds the BREAK state to rx_state_t.
package uart_pkg;

  // Legal oversampling ratios
  localparam int UART_OS_8  = 8;
  localparam int UART_OS_16 = 16;

  // Receiver frame states; BREAK exists only when break detection is built in
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
`ifdef UART_RX_BREAK_DET_EN
    , BREAK
`endif
  } rx_state_t;

  // Width of the tick counter for a legal oversampling ratio
  function automatic int os_cnt_width(input int os);
    return (os == UART_OS_8) ? 3 : 4;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake of the receive FIFO.
// valid/ready: the head entry transfers on every clk edge where rx_valid and
// rx_ready are both high; while rx_valid && !rx_ready the head is held stable.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data, rx_frame_err, rx_parity_err, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_frame_err, rx_parity_err, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with a registered head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head register tracks the entry that will be at the front after each
// edge and holds its last value once the FIFO drains.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    nxt_level;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a write when the same edge frees a slot
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = head_q;

  // Next pointers and next head entry, bypassing the write data when the
  // slot being written becomes the new head
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(push_ok);
    rd_ptr_d  = rd_ptr_q + PW'(pop_ok);
    nxt_level = wr_ptr_d - rd_ptr_d;
    head_d    = head_q;
    if (nxt_level != '0) begin
      if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = wdata;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Pointer and head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are only read once written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver feeding a receive FIFO.
// Parameters: DATA_BITS (5..9), OVERSAMPLE (8 or 16), FIFO_DEPTH (2..16, pow2).
// Optional break detection: define UART_RX_BREAK_DET_EN to add rx_break and
// the BREAK state; otherwise an all-zero frame is stored with frame_err set.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        os_tick,
  input  logic                        rx,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_odd,
  input  logic                        cfg_stop2,
  uart_rx_fifo_if.master              rd,
  output logic                        rx_overrun,
  input  logic                        clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`ifdef UART_RX_BREAK_DET_EN
  output logic                        rx_break,
`endif
  output rx_state_t                   dbg_state
);

  localparam int OS_W = os_cnt_width(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);
  localparam int EW   = DATA_BITS + 2;

  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BIT_LAST = BI_W'(DATA_BITS - 1);

  // One received character as stored in the FIFO
  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

  // Synchroniser
  logic [1:0] sync_q, sync_d;
  logic       rxs;

  // Frame state machine
  rx_state_t            state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                 par_bit_q, par_bit_d;
  logic                 stop_zero_q, stop_zero_d;
  logic                 rx_break_q, rx_break_d;
  logic                 body_zero;
  logic                 is_break;
`endif

  // Frame completion and FIFO write
  logic                 frame_done;
  logic                 done_frame_err;
  logic                 fifo_push;
  rx_entry_t            push_entry;
  rx_entry_t            head;
  logic [EW-1:0]        fifo_head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop_ok;

  // Overrun
  logic                 rx_overrun_q, rx_overrun_d;

  assign sync_d = {sync_q[0], rx};
  assign rxs    = sync_q[1];

  // Two-flop synchroniser on the raw line, idles high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Next-state logic; everything advances only on os_tick
  always_comb begin
    state_d        = state_q;
    os_cnt_d       = os_cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    par_err_d      = par_err_q;
    frame_err_d    = frame_err_q;
    par_en_d       = par_en_q;
    par_odd_d      = par_odd_q;
    stop2_d        = stop2_q;
    frame_done     = 1'b0;
    done_frame_err = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    par_bit_d      = par_bit_q;
    stop_zero_d    = stop_zero_q;
    rx_break_d     = 1'b0;
    body_zero      = (shift_q == '0) && (!par_en_q || !par_bit_q);
    is_break       = 1'b0;
`endif
    if (os_tick) begin
      case (state_q)
        IDLE: begin
          os_cnt_d = '0;
          if (!rxs) state_d = START;
        end
        START: begin
          if (os_cnt_q == OS_MID) begin
            os_cnt_d = '0;
            if (!rxs) begin
              // Start bit confirmed: freeze the line configuration
              bit_idx_d   = '0;
              par_err_d   = 1'b0;
              frame_err_d = 1'b0;
              par_en_d    = cfg_parity_en;
              par_odd_d   = cfg_parity_odd;
              stop2_d     = cfg_stop2;
              state_d     = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        DATA: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d           = '0;
            shift_d[bit_idx_q] = rxs;
            if (bit_idx_q == BIT_LAST) begin
              state_d = par_en_q ? PARITY : STOP1;
            end else begin
              bit_idx_d = bit_idx_q + BI_W'(1);
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        PARITY: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d  = '0;
            par_err_d = (^shift_q) ^ rxs ^ par_odd_q;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_d = rxs;
`endif
            state_d   = STOP1;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        STOP1: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d    = '0;
            frame_err_d = ~rxs;
`ifdef UART_RX_BREAK_DET_EN
            stop_zero_d = ~rxs;
`endif
            if (stop2_q) begin
              state_d = STOP2;
            end else begin
              // Finish at mid-stop so a following start edge is not missed
              frame_done     = 1'b1;
              done_frame_err = ~rxs;
`ifdef UART_RX_BREAK_DET_EN
              is_break       = body_zero && !rxs;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        STOP2: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d       = '0;
            frame_done     = 1'b1;
            done_frame_err = frame_err_q | ~rxs;
            frame_err_d    = done_frame_err;
`ifdef UART_RX_BREAK_DET_EN
            is_break       = body_zero && stop_zero_q && !rxs;
`endif
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        BREAK: begin
          // Hold off until the line has returned to idle
          os_cnt_d = '0;
          if (rxs) state_d = IDLE;
        end
`endif
        default: begin
          os_cnt_d = '0;
          state_d  = IDLE;
        end
      endcase
    end
    if (frame_done) begin
      state_d = IDLE;
`ifdef UART_RX_BREAK_DET_EN
      if (is_break) begin
        rx_break_d = 1'b1;
        state_d    = BREAK;
      end
`endif
    end
  end

  // Frame state machine registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q   <= 1'b0;
      stop_zero_q <= 1'b0;
      rx_break_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q   <= par_bit_d;
      stop_zero_q <= stop_zero_d;
      rx_break_q  <= rx_break_d;
`endif
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  assign rx_break  = rx_break_q;
  assign fifo_push = frame_done && !is_break;
`else
  assign fifo_push = frame_done;
`endif

  assign push_entry.frame_err  = done_frame_err;
  assign push_entry.parity_err = par_err_q;
  assign push_entry.data       = shift_q;

  assign pop_ok = rd.rx_valid && rd.rx_ready;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (rd.rx_ready),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign head             = fifo_head;
  assign rd.rx_data       = head.data;
  assign rd.rx_frame_err  = head.frame_err;
  assign rd.rx_parity_err = head.parity_err;
  assign rd.rx_valid      = !fifo_empty;

  // A new drop takes priority over a clear in the same clk
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (clr_overrun) rx_overrun_d = 1'b0;
    if (fifo_push && fifo_full && !pop_ok) rx_overrun_d = 1'b1;
  end

  // Sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign rx_overrun = rx_overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 8-bit data, 16x oversampling, 4-entry FIFO.
// Honours UART_RX_BREAK_DET_EN when the design is built with it.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = TICK_DIV * OS;

  logic      clk;
  logic      rst_n;
  logic      os_tick;
  logic      rx;
  logic      cfg_parity_en;
  logic      cfg_parity_odd;
  logic      cfg_stop2;
  logic      rx_overrun;
  logic      clr_overrun;
  logic [2:0] fifo_level;
  rx_state_t dbg_state;
`ifdef UART_RX_BREAK_DET_EN
  logic      rx_break;
  int        brk_cnt;
`endif

  uart_rx_fifo_if #(.DATA_BITS(8)) rd ();

  uart_rx_fifo #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .os_tick        (os_tick),
    .rx             (rx),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .rd             (rd),
    .rx_overrun     (rx_overrun),
    .clr_overrun    (clr_overrun),
    .fifo_level     (fifo_level),
`ifdef UART_RX_BREAK_DET_EN
    .rx_break       (rx_break),
`endif
    .dbg_state      (dbg_state)
  );

  // Scoreboard: {frame_err, parity_err, data}
  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset / tick ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : tick_gen
    int tdiv;
    tdiv    = 0;
    os_tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv    = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
      os_tick = (tdiv == 0);
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  initial begin
    brk_cnt = 0;
    forever begin
      @(negedge clk);
      if (rx_break) brk_cnt++;
    end
  end
`endif

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input logic pb,
                            input bit two, input logic s1, input logic s2, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit(pb);
    drive_bit(s1);
    if (two) drive_bit(s2);
    for (int i = 0; i < gap; i++) drive_bit(1'b1);
    rx = 1'b1;
  endtask

  task automatic exp_push(input logic fe, input logic pe, input logic [7:0] d);
    exp_q.push_back({fe, pe, d});
  endtask

  task automatic set_cfg(input logic pe, input logic po, input logic s2);
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_stop2      = s2;
  endtask

  // Pop the head and compare it with the oldest expected entry
  task automatic pop_one();
    logic [9:0] e;
    int t;
    t = 0;
    while (!rd.rx_valid && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("valid_wait", 32'(rd.rx_valid), 32'd1);
    if (!rd.rx_valid) return;
    check("level", 32'(fifo_level), 32'(exp_q.size()));
    e = exp_q.pop_front();
    check("data", 32'(rd.rx_data), 32'(e[7:0]));
    check("parity_err", 32'(rd.rx_parity_err), 32'(e[8]));
    check("frame_err", 32'(rd.rx_frame_err), 32'(e[9]));
    rd.rx_ready = 1'b1;
    @(negedge clk);
    rd.rx_ready = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_one();
    check("drained_valid", 32'(rd.rx_valid), 32'd0);
    check("drained_level", 32'(fifo_level), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic       pe, po, two, cor, pb, s1, s2;
    rst_n       = 1'b0;
    rx          = 1'b1;
    clr_overrun = 1'b0;
    rd.rx_ready = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_valid", 32'(rd.rx_valid), 32'd0);
    check("rst_data", 32'(rd.rx_data), 32'd0);
    check("rst_ferr", 32'(rd.rx_frame_err), 32'd0);
    check("rst_perr", 32'(rd.rx_parity_err), 32'd0);
    check("rst_ovr", 32'(rx_overrun), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef UART_RX_BREAK_DET_EN
    check("rst_break", 32'(rx_break), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 8N1 back-to-back
    exp_push(1'b0, 1'b0, 8'hA5);
    exp_push(1'b0, 1'b0, 8'h3C);
    send_frame(8'hA5, 0, 1'b0, 0, 1'b1, 1'b1, 0);
    send_frame(8'h3C, 0, 1'b0, 0, 1'b1, 1'b1, 1);
    drain();

    // 8E1 wrong parity, correct parity, then 8O1 correct parity
    set_cfg(1'b1, 1'b0, 1'b0);
    exp_push(1'b0, 1'b1, 8'h07);
    send_frame(8'h07, 1, 1'b0, 0, 1'b1, 1'b1, 1);
    exp_push(1'b0, 1'b0, 8'h07);
    send_frame(8'h07, 1, 1'b1, 0, 1'b1, 1'b1, 1);
    set_cfg(1'b1, 1'b1, 1'b0);
    exp_push(1'b0, 1'b0, 8'h07);
    send_frame(8'h07, 1, 1'b0, 0, 1'b1, 1'b1, 1);
    drain();

    // Config change in mid-frame must not affect that frame
    set_cfg(1'b1, 1'b0, 1'b0);
    exp_push(1'b0, 1'b1, 8'h07);
    fork
      send_frame(8'h07, 1, 1'b0, 0, 1'b1, 1'b1, 1);
      begin
        repeat (3 * BIT_CLKS) @(negedge clk);
        set_cfg(1'b0, 1'b1, 1'b1);
      end
    join
    drain();

    // 8N2 with a bad second stop bit, then a clean one
    set_cfg(1'b0, 1'b0, 1'b1);
    exp_push(1'b1, 1'b0, 8'h55);
    send_frame(8'h55, 0, 1'b0, 1, 1'b1, 1'b0, 1);
    exp_push(1'b0, 1'b0, 8'h55);
    send_frame(8'h55, 0, 1'b0, 1, 1'b1, 1'b1, 1);
    drain();

    // Overrun: five characters into four entries
    set_cfg(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_push(1'b0, 1'b0, 8'(i));
      send_frame(8'(i), 0, 1'b0, 0, 1'b1, 1'b1, 0);
    end
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("ovr_level", 32'(fifo_level), 32'd4);
    check("ovr_set", 32'(rx_overrun), 32'd1);
    drain();
    check("ovr_sticky", 32'(rx_overrun), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("ovr_clr", 32'(rx_overrun), 32'd0);

    // Short glitch is a false start
    rx = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("glitch_state", 32'(dbg_state), 32'(IDLE));
    check("glitch_valid", 32'(rd.rx_valid), 32'd0);
    check("glitch_level", 32'(fifo_level), 32'd0);

    // Reset mid-DATA with two entries queued
    send_frame(8'h11, 0, 1'b0, 0, 1'b1, 1'b1, 0);
    send_frame(8'h22, 0, 1'b0, 0, 1'b1, 1'b1, 0);
    check("pre_rst_level", 32'(fifo_level), 32'd2);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(rd.rx_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    exp_push(1'b0, 1'b0, 8'h9E);
    send_frame(8'h9E, 0, 1'b0, 0, 1'b1, 1'b1, 1);
    drain();

    // Random frames with random line configuration
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < int'($urandom_range(2, 4)); k++) begin
        d   = 8'($urandom_range(0, 255));
        pe  = 1'($urandom_range(0, 1));
        po  = 1'($urandom_range(0, 1));
        two = 1'($urandom_range(0, 1));
        cor = 1'($urandom_range(0, 1));
        s1  = ($urandom_range(0, 3) != 0);
        s2  = ($urandom_range(0, 3) != 0);
        if (d == 8'h00) s1 = 1'b1;
        pb  = (^d) ^ po ^ cor;
        set_cfg(pe, po, two);
        exp_push(~s1 | (two & ~s2), pe & cor, d);
        send_frame(d, pe, pb, two, s1, s2, 1);
      end
      drain();
    end

    // All-zero frame
    set_cfg(1'b0, 1'b0, 1'b0);
`ifdef UART_RX_BREAK_DET_EN
    brk_cnt = 0;
    rx = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("break_pulses", 32'(brk_cnt), 32'd1);
    check("break_level", 32'(fifo_level), 32'd0);
    check("break_state", 32'(dbg_state), 32'(IDLE));
    exp_push(1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A, 0, 1'b0, 0, 1'b1, 1'b1, 1);
    drain();
`else
    exp_push(1'b1, 1'b0, 8'h00);
    send_frame(8'h00, 0, 1'b0, 0, 1'b0, 1'b1, 2);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
